// File: rtl/imm_ext_pkg.sv
// Shared definitions for the immediate extender pipeline.
// Holds the 2-bit extension mode type and its four encodings.
package imm_ext_pkg;

  typedef logic [1:0] ext_mode_t;

  localparam ext_mode_t EXT_ZERO   = 2'b00;
  localparam ext_mode_t EXT_SIGN   = 2'b01;
  localparam ext_mode_t EXT_UPPER  = 2'b10;
  localparam ext_mode_t EXT_BRANCH = 2'b11;

endpackage

// File: rtl/imm_ext_core.sv
// Combinational immediate extender.
// Ports:
//   imm  - raw IN_W-bit immediate
//   mode - extension mode (zero, sign, upper, branch)
//   ext  - OUT_W-bit extended operand
module imm_ext_core
  import imm_ext_pkg::*;
#(
  parameter int unsigned IN_W  = 16,
  parameter int unsigned OUT_W = 32
) (
  input  logic [IN_W-1:0]  imm,
  input  ext_mode_t        mode,
  output logic [OUT_W-1:0] ext
);

  logic [OUT_W-1:0] sign_ext;

  always_comb begin
    sign_ext = {{(OUT_W-IN_W){imm[IN_W-1]}}, imm};
    ext      = '0;
    case (mode)
      EXT_ZERO:   ext = {{(OUT_W-IN_W){1'b0}}, imm};
      EXT_SIGN:   ext = sign_ext;
      EXT_UPPER:  ext = {imm, {(OUT_W-IN_W){1'b0}}};
      // Word-offset branch target: top two sign bits fall off the end.
      EXT_BRANCH: ext = {sign_ext[OUT_W-3:0], 2'b00};
      default:    ext = '0;
    endcase
  end

endmodule

// File: rtl/imm_ext_pipe.sv
// Pipelined immediate extender with a DEPTH-entry circular output queue.
// Ports:
//   clk, rst           - clock and synchronous active-high reset
//   flush              - discard all queued results
//   in_valid/in_ready  - input handshake; in_imm/in_mode are the item
//   out_valid/out_ready- output handshake; out_data is the queue head
//   occupancy          - number of queued results
module imm_ext_pipe
  import imm_ext_pkg::*;
#(
  parameter int unsigned IN_W  = 16,
  parameter int unsigned OUT_W = 32,
  parameter int unsigned DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [IN_W-1:0]            in_imm,
  input  ext_mode_t                  in_mode,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [OUT_W-1:0]           out_data,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int unsigned OCC_W = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

  logic [OUT_W-1:0] mem_q [DEPTH];
  logic [OUT_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic [OUT_W-1:0] ext;
  logic             push, pop;

  imm_ext_core #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) u_core (
    .imm  (in_imm),
    .mode (in_mode),
    .ext  (ext)
  );

  // in_ready only looks at registered occupancy, so a full queue never
  // accepts even if the head pops in the same cycle.
  assign in_ready  = (occ_q < OCC_FULL);
  assign out_valid = (occ_q != '0);
  assign out_data  = mem_q[rd_ptr_q];
  assign occupancy = occ_q;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      occ_d    = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = ext;
        wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   occ_d = occ_q + 1'b1;
        2'b01:   occ_d = occ_q - 1'b1;
        default: occ_d = occ_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Drives three queue depths (1, 2, 3) in lockstep from the same stimulus and
// compares each against a queue-based reference model, plus directed checks.
module tb_imm_ext_pipe;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [15:0] in_imm;
  logic [1:0]  in_mode;

  logic        ir_w [3];
  logic        ov_w [3];
  logic [31:0] od_w [3];
  logic [1:0]  occ_w [3];
  logic [0:0]  occ0;
  logic [1:0]  occ1, occ2;

  int          total = 0;
  int          bad   = 0;
  int          depth_of [3] = '{1, 2, 3};
  logic [31:0] mq [3][$];

  always #5 clk = ~clk;

  assign occ_w[0] = {1'b0, occ0};
  assign occ_w[1] = occ1;
  assign occ_w[2] = occ2;

  imm_ext_pipe #(.IN_W(16), .OUT_W(32), .DEPTH(1)) u_d1 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir_w[0]),
    .in_imm(in_imm), .in_mode(in_mode), .out_valid(ov_w[0]), .out_ready(out_ready),
    .out_data(od_w[0]), .occupancy(occ0)
  );
  imm_ext_pipe #(.IN_W(16), .OUT_W(32), .DEPTH(2)) u_d2 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir_w[1]),
    .in_imm(in_imm), .in_mode(in_mode), .out_valid(ov_w[1]), .out_ready(out_ready),
    .out_data(od_w[1]), .occupancy(occ1)
  );
  imm_ext_pipe #(.IN_W(16), .OUT_W(32), .DEPTH(3)) u_d3 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir_w[2]),
    .in_imm(in_imm), .in_mode(in_mode), .out_valid(ov_w[2]), .out_ready(out_ready),
    .out_data(od_w[2]), .occupancy(occ2)
  );

  // Extension rules written as plain arithmetic on the signed/unsigned value.
  function automatic logic [31:0] ref_ext(logic [15:0] imm, logic [1:0] mode);
    int s;
    s = int'($signed(imm));
    case (mode)
      2'd0:    return 32'(imm);
      2'd1:    return 32'(s);
      2'd2:    return 32'(imm) * 32'h0001_0000;
      default: return 32'(s * 4);
    endcase
  endfunction

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One clock: compare every DUT to its model before the edge, then advance
  // the models with the inputs currently applied.
  task automatic cyc();
    int  n;
    logic acc;
    logic pop;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      n = mq[k].size();
      check($sformatf("in_ready_d%0d", depth_of[k]), 32'(ir_w[k]), 32'(n < depth_of[k]));
      check($sformatf("out_valid_d%0d", depth_of[k]), 32'(ov_w[k]), 32'(n != 0));
      check($sformatf("occupancy_d%0d", depth_of[k]), 32'(occ_w[k]), 32'(n));
      if (n != 0) check($sformatf("out_data_d%0d", depth_of[k]), od_w[k], mq[k][0]);
    end
    for (int k = 0; k < 3; k++) begin
      if (rst || flush) begin
        mq[k].delete();
      end else begin
        acc = in_valid && (mq[k].size() < depth_of[k]);
        pop = out_ready && (mq[k].size() != 0);
        if (pop) void'(mq[k].pop_front());
        if (acc) mq[k].push_back(ref_ext(in_imm, in_mode));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0;
    in_imm   = '0;
    in_mode  = 2'bxx;
    flush    = 1'b0;
  endtask

  task automatic offer(logic [15:0] imm, logic [1:0] mode);
    in_valid = 1'b1;
    in_imm   = imm;
    in_mode  = mode;
  endtask

  logic [15:0] mode_imm [5] = '{16'h8001, 16'h8001, 16'h8001, 16'h8001, 16'h7FFF};
  logic [1:0]  mode_sel [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3};
  logic [31:0] mode_exp [5] = '{32'h0000_8001, 32'hFFFF_8001, 32'h8001_0000,
                                32'hFFFE_0004, 32'h0001_FFFC};

  initial begin
    rst = 1'b1;
    out_ready = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check("rst_in_ready", 32'(ir_w[k]), 32'd1);
      check("rst_out_valid", 32'(ov_w[k]), 32'd0);
      check("rst_out_data", od_w[k], 32'd0);
      check("rst_occupancy", 32'(occ_w[k]), 32'd0);
    end

    // Mode table, out_ready high.
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      offer(mode_imm[i], mode_sel[i]);
      cyc();
      idle_inputs();
      check($sformatf("mode%0d", i), od_w[1], mode_exp[i]);
      cyc();
    end

    // Back-pressure on the depth-2 queue.
    out_ready = 1'b0;
    offer(16'h8001, 2'd0); cyc();
    offer(16'h7FFF, 2'd1); cyc();
    check("bp_full_occ", 32'(occ1), 32'd2);
    check("bp_full_rdy", 32'(ir_w[1]), 32'd0);
    offer(16'h1234, 2'd2); cyc();
    check("bp_no_accept", 32'(occ1), 32'd2);
    check("bp_hold_a", od_w[1], 32'h0000_8001);
    out_ready = 1'b1;
    cyc();
    check("bp_pop_only", 32'(occ1), 32'd1);
    check("bp_head_b", od_w[1], 32'h0000_7FFF);
    cyc();
    idle_inputs();
    check("bp_head_c", od_w[1], 32'h1234_0000);
    cyc();

    // Flush beats a same-cycle accept and pop.
    out_ready = 1'b0;
    offer(16'h00AA, 2'd0); cyc();
    check("fl_occ1", 32'(occ1), 32'd1);
    offer(16'h5555, 2'd1);
    flush = 1'b1;
    out_ready = 1'b1;
    cyc();
    idle_inputs();
    check("fl_occ0", 32'(occ1), 32'd0);
    check("fl_valid0", 32'(ov_w[1]), 32'd0);
    cyc();
    check("fl_never", 32'(ov_w[1]), 32'd0);

    // Reset mid-stream with two items queued.
    out_ready = 1'b0;
    offer(16'h0F0F, 2'd1); cyc();
    offer(16'hF0F0, 2'd2); cyc();
    idle_inputs();
    rst = 1'b1; cyc();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check("mrst_in_ready", 32'(ir_w[k]), 32'd1);
      check("mrst_out_valid", 32'(ov_w[k]), 32'd0);
      check("mrst_out_data", od_w[k], 32'd0);
      check("mrst_occupancy", 32'(occ_w[k]), 32'd0);
    end

    // Ten-item stream with out_ready toggling, then drain.
    for (int i = 0; i < 10; i++) begin
      offer(16'($urandom), 2'($urandom));
      out_ready = i[0];
      cyc();
    end
    idle_inputs();
    out_ready = 1'b1;
    repeat (4) cyc();

    // Randomized traffic with occasional flush and reset.
    for (int i = 0; i < 500; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_imm    = 16'($urandom);
      in_mode   = in_valid ? 2'($urandom) : 2'bxx;
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 31) == 0);
      rst       = ($urandom_range(0, 63) == 0);
      cyc();
    end
    idle_inputs();
    rst = 1'b0;
    out_ready = 1'b1;
    repeat (4) cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
